trace_capture_buffer: RTL and testbench
=======================================

# trace_capture_buffer

Writer side of the waveform display path. Acquires a triggered record of 12-bit ADC samples into a ping-pong line buffer, one sample per screen column, and serves the stored sample for the current `pixel_x` to the vertical pixel discriminator. While the display scans one bank, capture fills the other. Banks swap only at a frame boundary, so a displayed frame never tears.

## Interface
Parameters:
- `DATA_W`, 12: sample width, unsigned.
- `DEPTH`, 800: samples per record, equal to the visible columns.
- `ADDR_W`, 10: address/pixel_x width, with 2^ADDR_W ≥ DEPTH.
- `TRIG_LEVEL`, 2048: rising-edge trigger threshold, unsigned.
- `AUTO_TIMEOUT`, 4096: valid samples in ARMED before an auto-trigger. Used only with `TRACE_AUTO_TRIG_EN`.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `sample_in` in DATA_W: ADC sample.
- `sample_valid` in 1: `sample_in` is valid this cycle.
- `frame_start` in 1: one-cycle pulse at the start of each display frame (vsync).
- `pixel_x` in ADDR_W: current horizontal pixel position.
- `value_out` out DATA_W: stored sample for `pixel_x`, registered.
- `frame_valid` out 1: the read bank holds a completed record.
- `capture_done` out 1: one-cycle pulse when the last sample of a record is written.
- `armed` out 1: high in state ARMED.

## Operation
- States: IDLE, ARMED, CAPTURE, HOLD.
- IDLE → ARMED on `frame_start`.
- ARMED → CAPTURE on a trigger, which requires `sample_valid` && `prev_sample` < TRIG_LEVEL && `sample_in` ≥ TRIG_LEVEL.
  - The triggering sample is written to write-bank address 0.
  - The write address then becomes 1.
- CAPTURE:
  - Each `sample_valid` writes `sample_in` at the write address, then the address increments.
  - The write at address DEPTH-1 moves the FSM to HOLD and pulses `capture_done`.
- HOLD → ARMED on `frame_start`. In the same edge:
  - read and write banks swap;
  - `frame_valid` is set;
  - the write address clears.
- `frame_start` in ARMED or CAPTURE is ignored. The display keeps the old bank.
- `prev_sample` updates on every `sample_valid` in every state.
- Samples without `sample_valid` are neither written nor counted.
- Read path:
  - `value_out` ← read bank[`pixel_x`] when `frame_valid` && `pixel_x` < DEPTH;
  - otherwise `value_out` ← 0.
- The write and read ports are independent. Reads of the read bank never see writes in the same frame.
- Comparisons are unsigned at DATA_W bits. The address counter never exceeds DEPTH-1.

## Timing
- Reset values:
  - state IDLE; `value_out` 0; `frame_valid` 0; `capture_done` 0; `armed` 0;
  - write address 0; bank select 0; `prev_sample` 0.
  - Memory contents are not reset.
- Read latency: 1 cycle from `pixel_x` to `value_out`.
- Trigger to first write: the trigger cycle itself.
- `capture_done` is high on the cycle after the final write edge, for exactly 1 cycle.
- Simultaneous events:
  - `frame_start` on the same cycle as the final write: the FSM enters HOLD with no swap. The swap waits for the next `frame_start`.
  - `frame_start` together with a valid sample in HOLD: the swap is taken and the sample only updates `prev_sample`.
  - A trigger is possible from the first valid sample after entering ARMED.
- Reset mid-capture: immediate return to IDLE. `frame_valid` drops and `value_out` reads 0 until the next completed swap.
- `armed` is registered and follows the state.

## Configuration
- `TRACE_AUTO_TRIG_EN` defined:
  - ARMED counts valid samples.
  - When the count reaches AUTO_TIMEOUT without a trigger, the current valid sample is treated as a trigger.
  - The counter clears on entry to ARMED.
- `TRACE_AUTO_TRIG_EN` undefined:
  - ARMED waits indefinitely.
  - No counter is synthesized.
  - AUTO_TIMEOUT is unused.

## Test plan
- **Reset read:** reset, then sweep `pixel_x` 0..799 → `value_out` = 0 and `frame_valid` = 0 throughout.
- **Ramp capture:**
  - Stimulus: `frame_start`, then valid samples 0,100,…,2000,2100,2101,… plus 800 more.
  - Required: the trigger fires on 2100; `capture_done` pulses once; after the next `frame_start`, `pixel_x` = 0 gives 2100 and `pixel_x` = 5 gives 2105 one cycle later.
- **No-tear:** a second record is captured while the first is displayed → `value_out` for the frame still shows the first record. The swap occurs only at the `frame_start` that follows HOLD.
- **Boundary:**
  - `pixel_x` = 799 → last sample.
  - `pixel_x` = 800 or 1023 → 0.
  - `frame_start` coincident with the final write → no swap until the following `frame_start`.
- **Reset mid-capture:** assert `reset` after 300 written samples → IDLE, `frame_valid` 0; a fresh capture restarts at address 0.
- **Auto-trigger:**
  - With `TRACE_AUTO_TRIG_EN`: a constant input of 100 triggers on the 4096th valid sample.
  - Without it: `armed` stays high indefinitely.

Source files
------------

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer
//
// Writer side of the waveform display path. A triggered record of DEPTH
// samples is captured into one bank of a ping-pong line buffer while the
// display reads the other bank, one stored sample per screen column. The banks
// swap only at a frame_start that arrives after a record has completed, so a
// displayed frame never mixes two records.
//
// Ports:
//   clk          in            system clock, rising edge
//   reset        in            asynchronous, active-high
//   sample_in    in  DATA_W    ADC sample (unsigned)
//   sample_valid in            sample_in is valid this cycle
//   frame_start  in            one-cycle pulse at each display frame start
//   pixel_x      in  ADDR_W    current horizontal pixel position
//   value_out    out DATA_W    stored sample for pixel_x, one cycle later
//   frame_valid  out           read bank holds a completed record
//   capture_done out           one-cycle pulse after the last write of a record
//   armed        out           FSM is in ARMED
//
// Handshake: a sample is consumed on every rising edge where sample_valid is
// high; there is no back-pressure, so sample_valid low means "no sample".
//
// Optional feature: define TRACE_AUTO_TRIG_EN to force a trigger on the
// AUTO_TIMEOUT-th valid sample seen in ARMED without a real trigger.
//
// Debug: state_q is the FSM state register (IDLE/ARMED/CAPTURE/HOLD).

module trace_capture_buffer #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 800,
    parameter int ADDR_W       = 10,
    parameter int TRIG_LEVEL   = 2048,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] pixel_x,
    output logic [DATA_W-1:0] value_out,
    output logic              frame_valid,
    output logic              capture_done,
    output logic              armed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] TRIG_TH   = DATA_W'(TRIG_LEVEL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              rd_bank_q, rd_bank_d;   // bank the display reads; capture writes the other
    logic [DATA_W-1:0] prev_sample_q, prev_sample_d;
    logic              frame_valid_q, frame_valid_d;
    logic              capture_done_q, capture_done_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] value_out_q, value_out_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_ptr;
    logic              trig_edge;
    logic              auto_hit;

    logic [DATA_W-1:0] mem0 [0:DEPTH-1];
    logic [DATA_W-1:0] mem1 [0:DEPTH-1];

    assign trig_edge = sample_valid && (prev_sample_q < TRIG_TH) && (sample_in >= TRIG_TH);

`ifdef TRACE_AUTO_TRIG_EN
    localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);

    logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;

    // The counter holds the number of valid samples already seen in ARMED, so
    // the AUTO_TIMEOUT-th valid sample finds it at AUTO_TIMEOUT-1. Outside
    // ARMED it is held at zero, which clears it on every entry to ARMED.
    assign auto_hit = sample_valid && (auto_cnt_q == CNT_W'(AUTO_TIMEOUT - 1));

    always_comb begin
        auto_cnt_d = '0;
        if (state_q == ARMED) begin
            auto_cnt_d = sample_valid ? auto_cnt_q + 1'b1 : auto_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic unused_auto_timeout;

    assign auto_hit            = 1'b0;
    assign unused_auto_timeout = (AUTO_TIMEOUT == 0);
`endif

    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        rd_bank_d      = rd_bank_q;
        prev_sample_d  = sample_valid ? sample_in : prev_sample_q;
        frame_valid_d  = frame_valid_q;
        capture_done_d = 1'b0;
        wr_en          = 1'b0;
        wr_ptr         = wr_addr_q;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = ARMED;
                    wr_addr_d = '0;
                end
            end
            ARMED: begin
                // The triggering sample itself is the first sample of the record.
                if (trig_edge || auto_hit) begin
                    wr_en     = 1'b1;
                    wr_ptr    = '0;
                    wr_addr_d = ADDR_W'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d        = HOLD;
                        capture_done_d = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // A frame_start that coincided with the final write was seen
                // in CAPTURE and ignored, so the swap waits for the next one.
                if (frame_start) begin
                    rd_bank_d     = ~rd_bank_q;
                    frame_valid_d = 1'b1;
                    wr_addr_d     = '0;
                    state_d       = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        armed_d = (state_d == ARMED);

        value_out_d = '0;
        if (frame_valid_q && ({1'b0, pixel_x} < DEPTH_X)) begin
            value_out_d = rd_bank_q ? mem1[pixel_x] : mem0[pixel_x];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_addr_q      <= '0;
            rd_bank_q      <= 1'b0;
            prev_sample_q  <= '0;
            frame_valid_q  <= 1'b0;
            capture_done_q <= 1'b0;
            armed_q        <= 1'b0;
            value_out_q    <= '0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            rd_bank_q      <= rd_bank_d;
            prev_sample_q  <= prev_sample_d;
            frame_valid_q  <= frame_valid_d;
            capture_done_q <= capture_done_d;
            armed_q        <= armed_d;
            value_out_q    <= value_out_d;
        end
    end

    // Line buffer storage is not reset; frame_valid gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (rd_bank_q) begin
                mem0[wr_ptr] <= sample_in;
            end else begin
                mem1[wr_ptr] <= sample_in;
            end
        end
    end

    assign value_out    = value_out_q;
    assign frame_valid  = frame_valid_q;
    assign capture_done = capture_done_q;
    assign armed        = armed_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
module tb_trace_capture_buffer;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 800;
    localparam int ADDR_W = 10;
    localparam int TRIG   = 2048;
    localparam int AUTO   = 4096;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_CAP   = 2;
    localparam int P_HOLD  = 3;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              frame_start;
    logic [ADDR_W-1:0] pixel_x;
    logic [DATA_W-1:0] value_out;
    logic              frame_valid;
    logic              capture_done;
    logic              armed;

    trace_capture_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .TRIG_LEVEL(TRIG), .AUTO_TIMEOUT(AUTO)
    ) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_start(frame_start), .pixel_x(pixel_x), .value_out(value_out),
        .frame_valid(frame_valid), .capture_done(capture_done), .armed(armed)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Record-level model: the record being captured is a queue of samples,
    // the displayed record is a plain array copied at the swap.
    int                m_phase;
    int                m_cnt;
    logic              m_fv;
    logic [DATA_W-1:0] m_prev;
    logic [DATA_W-1:0] m_disp [DEPTH];
    logic [DATA_W-1:0] m_rec [$];
    logic [DATA_W-1:0] exp_value;
    logic              exp_done;

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_cnt     = 0;
        m_fv      = 1'b0;
        m_prev    = '0;
        m_rec     = {};
        exp_value = '0;
        exp_done  = 1'b0;
    endtask

    task automatic model_edge(input logic fs, input logic sv,
                              input logic [DATA_W-1:0] s, input logic [ADDR_W-1:0] px);
        logic [DATA_W-1:0] nv;
        logic              hit;
        nv       = (m_fv && px < DEPTH) ? m_disp[px] : '0;
        exp_done = 1'b0;
        case (m_phase)
            P_IDLE: if (fs) begin m_phase = P_ARMED; m_cnt = 0; end
            P_ARMED: if (sv) begin
                hit = (m_prev < TRIG) && (s >= TRIG);
`ifdef TRACE_AUTO_TRIG_EN
                if (m_cnt + 1 == AUTO) hit = 1'b1;
`endif
                if (hit) begin
                    m_rec   = {s};
                    m_phase = P_CAP;
                end else begin
                    m_cnt++;
                end
            end
            P_CAP: if (sv) begin
                m_rec.push_back(s);
                if (m_rec.size() == DEPTH) begin
                    m_phase  = P_HOLD;
                    exp_done = 1'b1;
                end
            end
            default: if (fs) begin
                for (int i = 0; i < DEPTH; i++) m_disp[i] = m_rec[i];
                m_fv    = 1'b1;
                m_phase = P_ARMED;
                m_cnt   = 0;
            end
        endcase
        if (sv) m_prev = s;
        exp_value = nv;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic fs, input logic sv,
                        input logic [DATA_W-1:0] s, input logic [ADDR_W-1:0] px);
        @(negedge clk);
        frame_start  = fs;
        sample_valid = sv;
        sample_in    = s;
        pixel_x      = px;
        @(posedge clk);
        model_edge(fs, sv, s, px);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; frame_start = 1'b0; sample_valid = 1'b0; sample_in = '0; pixel_x = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (armed !== 1'b0 || capture_done !== 1'b0 || frame_valid !== 1'b0 || value_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs armed=%b done=%b fv=%b val=%0d exp all zero",
                     armed, capture_done, frame_valid, value_out);
        end
        for (int p = 0; p < DEPTH; p++) begin
            step(1'b0, 1'b0, '0, ADDR_W'(p));
            checks++;
            if (value_out !== exp_value || frame_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_read px=%0d val=%0d exp=%0d fv=%b exp=0", p, value_out, exp_value, frame_valid);
            end
        end
    endtask

    task automatic test_ramp();
        int done_cnt;
        step(1'b1, 1'b0, '0, '0);
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL ramp_armed got=%b exp=1", armed); end
        for (int k = 0; k <= 20; k++) step(1'b0, 1'b1, DATA_W'(k * 100), '0);
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL ramp_no_early_trig armed=%b exp=1", armed); end
        done_cnt = 0;
        for (int k = 0; k < DEPTH + 20; k++) begin
            step(1'b0, 1'b1, DATA_W'(2100 + k), '0);
            if (capture_done === 1'b1) done_cnt++;
            checks++;
            if (capture_done !== exp_done || armed !== (m_phase == P_ARMED)) begin
                failures++;
                $display("FAIL ramp_capture k=%0d done=%b exp=%b armed=%b", k, capture_done, exp_done, armed);
            end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL ramp_done_pulses got=%0d exp=1", done_cnt); end
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 10'd0);
        checks++;
        if (value_out !== 12'd2100 || value_out !== exp_value || frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL ramp_px0 val=%0d exp=2100 fv=%b", value_out, frame_valid);
        end
        step(1'b0, 1'b0, '0, 10'd5);
        checks++;
        if (value_out !== 12'd2105 || value_out !== exp_value) begin
            failures++;
            $display("FAIL ramp_px5 val=%0d exp=2105", value_out);
        end
    endtask

    task automatic test_no_tear();
        int n;
        step(1'b0, 1'b1, 12'd100, '0);
        step(1'b0, 1'b1, 12'd3000, '0);
        n = 0;
        while (m_phase != P_HOLD && n < 4000) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 DATA_W'($urandom_range(0, 4095)), ADDR_W'($urandom_range(0, 1023)));
            n++;
            checks++;
            if (value_out !== exp_value || frame_valid !== m_fv || capture_done !== exp_done) begin
                failures++;
                $display("FAIL no_tear_read px=%0d val=%0d exp=%0d fv=%b done=%b exp=%b",
                         pixel_x, value_out, exp_value, frame_valid, capture_done, exp_done);
            end
        end
        checks++;
        if (m_phase != P_HOLD) begin failures++; $display("FAIL no_tear_timeout cycles=%0d", n); end
        step(1'b0, 1'b0, '0, 10'd5);
        checks++;
        if (value_out !== 12'd2105) begin failures++; $display("FAIL no_tear_old_record val=%0d exp=2105", value_out); end
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 10'd0);
        checks++;
        if (value_out !== 12'd3000 || value_out !== exp_value) begin
            failures++;
            $display("FAIL no_tear_swap val=%0d exp=3000", value_out);
        end
    endtask

    task automatic test_boundary();
        logic [DATA_W-1:0] last_s;
        step(1'b0, 1'b0, '0, 10'd799);
        checks++;
        if (value_out !== exp_value) begin failures++; $display("FAIL bnd_px799 val=%0d exp=%0d", value_out, exp_value); end
        step(1'b0, 1'b0, '0, 10'd800);
        checks++;
        if (value_out !== '0) begin failures++; $display("FAIL bnd_px800 val=%0d exp=0", value_out); end
        step(1'b0, 1'b0, '0, 10'd1023);
        checks++;
        if (value_out !== '0) begin failures++; $display("FAIL bnd_px1023 val=%0d exp=0", value_out); end
        step(1'b0, 1'b1, 12'd100, '0);
        step(1'b0, 1'b1, 12'd2500, '0);
        for (int k = 0; k < DEPTH - 2; k++) step(1'b0, 1'b1, DATA_W'($urandom_range(0, 4095)), '0);
        last_s = DATA_W'($urandom_range(0, 4095));
        step(1'b1, 1'b1, last_s, '0);
        checks++;
        if (capture_done !== 1'b1 || armed !== 1'b0 || exp_done !== 1'b1) begin
            failures++;
            $display("FAIL bnd_coincident done=%b armed=%b exp done=1 armed=0", capture_done, armed);
        end
        step(1'b0, 1'b0, '0, 10'd0);
        checks++;
        if (value_out !== 12'd3000 || value_out !== exp_value) begin
            failures++;
            $display("FAIL bnd_no_swap val=%0d exp=3000", value_out);
        end
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 10'd0);
        checks++;
        if (value_out !== 12'd2500) begin failures++; $display("FAIL bnd_late_swap val=%0d exp=2500", value_out); end
        step(1'b0, 1'b0, '0, 10'd799);
        checks++;
        if (value_out !== last_s) begin failures++; $display("FAIL bnd_last val=%0d exp=%0d", value_out, last_s); end
    endtask

    task automatic test_reset_mid_capture();
        step(1'b0, 1'b1, 12'd100, '0);
        step(1'b0, 1'b1, 12'd2600, '0);
        for (int k = 0; k < 299; k++) step(1'b0, 1'b1, DATA_W'($urandom_range(0, 4095)), '0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (frame_valid !== 1'b0 || armed !== 1'b0 || value_out !== '0) begin
            failures++;
            $display("FAIL mid_reset fv=%b armed=%b val=%0d exp 0 0 0", frame_valid, armed, value_out);
        end
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, '0, 10'd3);
        checks++;
        if (value_out !== '0 || armed !== 1'b1) begin
            failures++;
            $display("FAIL mid_rearm val=%0d exp=0 armed=%b exp=1", value_out, armed);
        end
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, DATA_W'(3100 + k), '0);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 10'd0);
        checks++;
        if (value_out !== 12'd3100 || value_out !== exp_value) begin
            failures++;
            $display("FAIL mid_restart_px0 val=%0d exp=3100", value_out);
        end
        step(1'b0, 1'b0, '0, 10'd799);
        checks++;
        if (value_out !== 12'd3899) begin failures++; $display("FAIL mid_restart_px799 val=%0d exp=3899", value_out); end
    endtask

    task automatic test_auto_trig();
        for (int k = 0; k < AUTO - 1; k++) step(1'b0, 1'b1, 12'd100, '0);
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL auto_before armed=%b exp=1", armed); end
        step(1'b0, 1'b1, 12'd100, '0);
`ifdef TRACE_AUTO_TRIG_EN
        checks++;
        if (armed !== 1'b0 || m_phase != P_CAP) begin
            failures++;
            $display("FAIL auto_fire armed=%b exp=0", armed);
        end
`else
        for (int k = 0; k < 1000; k++) step(1'b0, 1'b1, 12'd100, '0);
        checks++;
        if (armed !== 1'b1 || m_phase != P_ARMED) begin
            failures++;
            $display("FAIL auto_wait armed=%b exp=1", armed);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; frame_start = 1'b0; sample_valid = 1'b0; sample_in = '0; pixel_x = '0;
        test_reset();
        test_ramp();
        test_no_tear();
        test_boundary();
        test_reset_mid_capture();
        test_auto_trig();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
